// File: rtl/mux_scan_if.sv
// Channel bus, mode/scan controls and the valid/ready output port of mux_scan_nx1.
// The slave modport is the multiplexer's view; master is the producer/consumer side.
interface mux_scan_if #(
   parameter int unsigned W       = 8,
   parameter int unsigned N       = 16,
   parameter int unsigned DWELL_W = 8
);
   localparam int unsigned SELW = $clog2(N);

   logic [N*W-1:0]     in_bus;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic               start;
   logic [N-1:0]       chan_mask;
   logic [DWELL_W-1:0] dwell;
   logic [W-1:0]       out_data;
   logic [SELW-1:0]    out_ch;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               scan_wrap;

   modport master (
      output in_bus, mode, sel, start, chan_mask, dwell, out_ready,
      input  out_data, out_ch, out_valid, busy, scan_wrap
   );

   modport slave (
      input  in_bus, mode, sel, start, chan_mask, dwell, out_ready,
      output out_data, out_ch, out_valid, busy, scan_wrap
   );
endinterface

// File: rtl/mux_scan_nx1.sv
// N-channel registered multiplexer: MANUAL select with 1-cycle latency, or SCAN
// round-robin over a captured channel mask with a dwell gap after each accepted word.
module mux_scan_nx1 #(
   parameter int unsigned W       = 8,
   parameter int unsigned N       = 16,
   parameter int unsigned DWELL_W = 8
) (
   input logic       clk,
   input logic       rst_n,
   mux_scan_if.slave io_mux
);
   localparam int unsigned SELW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_ACK, S_HOLD} state_t;

   state_t             r_state, w_state;
   logic [W-1:0]       r_data, w_data;
   logic [SELW-1:0]    r_ch, w_ch;
   logic               r_valid, w_valid;
   logic               r_busy, w_busy;
   logic               r_wrap, w_wrap;
   logic [DWELL_W-1:0] r_cnt, w_cnt;
   logic [DWELL_W-1:0] r_dwell, w_dwell;
   logic [N-1:0]       r_mask, w_mask;
   logic [SELW-1:0]    r_ptr, w_ptr;
   logic               w_adv;
   logic               w_load_ok;

   // Out-of-range indices (sel >= N) select zero.
   function automatic logic [W-1:0] f_chan(input logic [N*W-1:0] bus, input logic [SELW-1:0] idx);
      f_chan = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (idx == SELW'(k)) f_chan = bus[k*W +: W];
      end
   endfunction

   function automatic logic [SELW-1:0] f_lowest(input logic [N-1:0] mask);
      f_lowest = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (mask[k]) f_lowest = SELW'(k);
      end
   endfunction

   // Returns {wrap, next index}: next set bit above ptr, else wrap to the lowest.
   function automatic logic [SELW:0] f_next(input logic [N-1:0] mask, input logic [SELW-1:0] ptr);
      logic [SELW-1:0] idx;
      logic            wrap;
      idx  = f_lowest(mask);
      wrap = 1'b1;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (mask[k] && (SELW'(k) > ptr)) begin
            idx  = SELW'(k);
            wrap = 1'b0;
         end
      end
      f_next = {wrap, idx};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
         r_cnt   <= '0;
         r_dwell <= '0;
         r_mask  <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state;
         r_data  <= w_data;
         r_ch    <= w_ch;
         r_valid <= w_valid;
         r_busy  <= w_busy;
         r_wrap  <= w_wrap;
         r_cnt   <= w_cnt;
         r_dwell <= w_dwell;
         r_mask  <= w_mask;
         r_ptr   <= w_ptr;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_data    = r_data;
      w_ch      = r_ch;
      w_valid   = r_valid;
      w_wrap    = 1'b0;
      w_cnt     = r_cnt;
      w_dwell   = r_dwell;
      w_mask    = r_mask;
      w_ptr     = r_ptr;
      w_adv     = 1'b0;
      w_load_ok = !r_valid || io_mux.out_ready;

      case (r_state)
         S_IDLE: begin
            if (!io_mux.mode) begin
               if (w_load_ok) begin
                  w_data  = f_chan(io_mux.in_bus, io_mux.sel);
                  w_ch    = io_mux.sel;
                  w_valid = 1'b1;
               end
            end else if (io_mux.start && (io_mux.chan_mask != '0)) begin
               w_mask  = io_mux.chan_mask;
               w_dwell = io_mux.dwell;
               w_ptr   = f_lowest(io_mux.chan_mask);
               w_valid = 1'b0;
               w_state = S_LOAD;
            end else if (w_load_ok) begin
               w_valid = 1'b0;
            end
         end
         S_LOAD: begin
            w_data  = f_chan(io_mux.in_bus, r_ptr);
            w_ch    = r_ptr;
            w_valid = 1'b1;
            w_state = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (r_valid && io_mux.out_ready) begin
               w_valid = 1'b0;
               w_cnt   = r_dwell;
               if (r_dwell != '0) w_state = S_HOLD;
               else               w_adv   = 1'b1;
            end
         end
         S_HOLD: begin
            w_cnt = r_cnt - DWELL_W'(1);
            if (r_cnt == DWELL_W'(1)) w_adv = 1'b1;
         end
         default: w_state = S_IDLE;
      endcase

      if (w_adv) begin
         {w_wrap, w_ptr} = f_next(r_mask, r_ptr);
         w_state         = S_LOAD;
      end

      // Dropping mode aborts any scan, even over a same-cycle accept.
      if ((r_state != S_IDLE) && !io_mux.mode) begin
         w_state = S_IDLE;
         w_valid = 1'b0;
         w_wrap  = 1'b0;
      end

      w_busy = (w_state != S_IDLE);
   end

   assign io_mux.out_data  = r_data;
   assign io_mux.out_ch    = r_ch;
   assign io_mux.out_valid = r_valid;
   assign io_mux.busy      = r_busy;
   assign io_mux.scan_wrap = r_wrap;
endmodule
